// File: rtl/cpu_trace_checker.sv
// Run controller and write-back checker for the single-cycle core: holds the core in
// reset, then compares every register write-back against a preloaded expected trace.
module cpu_trace_checker #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = 4,
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_res,
  input  logic [IDX_W:0]    n_expected,
  input  logic              start,
  output logic              cpu_resetn,
  input  logic [DATA_W-1:0] cpu_pc,
  input  logic [DATA_W-1:0] cpu_eresult,
  input  logic              cpu_wreg,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [DATA_W-1:0] fail_pc,
  output logic [DATA_W-1:0] fail_got,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]    DEPTH_V   = (IDX_W+1)'(DEPTH);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD - 1);
  localparam logic [TO_W-1:0]   TO_V      = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_PASS, S_FAIL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] res;
  } entry_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W:0]    n_lat_q, n_lat_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0] fail_pc_q, fail_pc_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  entry_t mem [DEPTH];
  entry_t cur;
  logic   can_load, mem_we, start_run, hold_last, wb_match, wb_last, idle_hit;

  // Trace is only writable while the core is not running; contents survive reset.
  assign can_load  = (state_q == S_IDLE) || (state_q == S_PASS) || (state_q == S_FAIL);
  assign mem_we    = load_en && can_load && ({1'b0, load_idx} < DEPTH_V);
  assign start_run = start && can_load;
  assign cur       = mem[ptr_q];
  assign hold_last = (hold_cnt_q == HOLD_LAST);
  assign wb_match  = (cpu_pc == cur.pc) && (cpu_eresult == cur.res);
  assign wb_last   = ({1'b0, ptr_q} == n_lat_q - (IDX_W+1)'(1));
  assign idle_hit  = (idle_q + TO_W'(1) == TO_V);

  always_ff @(posedge clock) begin
    if (mem_we) mem[load_idx] <= '{pc: load_pc, res: load_res};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      idle_q      <= '0;
      ptr_q       <= '0;
      n_lat_q     <= '0;
      timeout_q   <= 1'b0;
      fail_idx_q  <= '0;
      fail_pc_q   <= '0;
      fail_got_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_q      <= idle_d;
      ptr_q       <= ptr_d;
      n_lat_q     <= n_lat_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
      fail_pc_q   <= fail_pc_d;
      fail_got_q  <= fail_got_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: if (start) state_d = S_HOLD;
      S_HOLD: if (hold_last) state_d = (n_lat_q == '0) ? S_PASS : S_RUN;
      S_RUN: begin
        // A write-back outranks a timeout landing on the same cycle.
        if (cpu_wreg) begin
          if (!wb_match)    state_d = S_FAIL;
          else if (wb_last) state_d = S_PASS;
        end else if (idle_hit) begin
          state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    idle_d      = idle_q;
    ptr_d       = ptr_q;
    n_lat_d     = n_lat_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    fail_pc_d   = fail_pc_q;
    fail_got_d  = fail_got_q;
    cycle_cnt_d = cycle_cnt_q;
    if (start_run) begin
      n_lat_d     = (n_expected > DEPTH_V) ? DEPTH_V : n_expected;
      hold_cnt_d  = '0;
      idle_d      = '0;
      ptr_d       = '0;
      timeout_d   = 1'b0;
      fail_idx_d  = '0;
      fail_pc_d   = '0;
      fail_got_d  = '0;
      cycle_cnt_d = '0;
    end else if (state_q == S_HOLD) begin
      if (!hold_last) hold_cnt_d = hold_cnt_q + HC_W'(1);
      ptr_d       = '0;
      idle_d      = '0;
      cycle_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (cpu_wreg) begin
        if (wb_match) begin
          ptr_d  = ptr_q + IDX_W'(1);
          idle_d = '0;
        end else begin
          timeout_d  = 1'b0;
          fail_idx_d = ptr_q;
          fail_pc_d  = cpu_pc;
          fail_got_d = cpu_eresult;
        end
      end else if (idle_hit) begin
        timeout_d  = 1'b1;
        fail_idx_d = ptr_q;
        fail_pc_d  = cpu_pc;
        fail_got_d = '0;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    cpu_resetn = (state_q == S_RUN);
    busy       = (state_q == S_HOLD) || (state_q == S_RUN);
    done       = (state_q == S_PASS) || (state_q == S_FAIL);
    pass       = (state_q == S_PASS);
  end

  assign timeout   = timeout_q;
  assign fail_idx  = fail_idx_q;
  assign fail_pc   = fail_pc_q;
  assign fail_got  = fail_got_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker; the bench plays the core by driving wreg pulses.
module tb_cpu_trace_checker;
  localparam int DATA_W = 32, DEPTH = 16, IDX_W = 4, HOLD = 4, TIMEOUT = 8, CNT_W = 3;

  logic              clock = 1'b0, reset = 1'b0;
  logic              load_en = 1'b0;
  logic [IDX_W-1:0]  load_idx = '0;
  logic [DATA_W-1:0] load_pc = '0, load_res = '0;
  logic [IDX_W:0]    n_expected = '0;
  logic              start = 1'b0;
  logic              cpu_resetn;
  logic [DATA_W-1:0] cpu_pc = '0, cpu_eresult = '0;
  logic              cpu_wreg = 1'b0;
  logic              busy, done, pass, timeout;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_pc, fail_got;
  logic [CNT_W-1:0]  cycle_cnt;

  int n_checks = 0, n_fail = 0;

  cpu_trace_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .HOLD(HOLD),
                      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_pc(load_pc), .load_res(load_res), .n_expected(n_expected), .start(start),
    .cpu_resetn(cpu_resetn), .cpu_pc(cpu_pc), .cpu_eresult(cpu_eresult),
    .cpu_wreg(cpu_wreg), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_idx(fail_idx), .fail_pc(fail_pc), .fail_got(fail_got), .cycle_cnt(cycle_cnt));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int idx, input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] res);
    load_en = 1'b1; load_idx = IDX_W'(idx); load_pc = pc; load_res = res;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load3();
    load(0, 32'h00, 32'd5);
    load(1, 32'h04, 32'd7);
    load(2, 32'h08, 32'd12);
  endtask

  task automatic kick(input int n);
    n_expected = (IDX_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with the core held in reset, leaving the bench at the first RUN cycle.
  task automatic wait_run(output int n);
    n = 0;
    while (!cpu_resetn && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic wb(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] res);
    cpu_wreg = 1'b1; cpu_pc = pc; cpu_eresult = res;
    tick();
    cpu_wreg = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({busy, done, pass, timeout, cpu_resetn} !== 5'b0 || fail_idx !== '0 ||
        fail_pc !== '0 || fail_got !== '0 || cycle_cnt !== '0) begin
      $display("FAIL reset_state: busy=%b done=%b pass=%b to=%b rn=%b idx=%0d pc=%0h got=%0h cnt=%0d, all zero required",
               busy, done, pass, timeout, cpu_resetn, fail_idx, fail_pc, fail_got, cycle_cnt);
      n_fail++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_pass();
    int n;
    load3();
    kick(3);
    wait_run(n);
    n_checks++;
    if (n !== HOLD) begin $display("FAIL pass_hold_cycles: got %0d, want %0d", n, HOLD); n_fail++; end
    wb(32'h00, 32'd5);
    wb(32'h04, 32'd7);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL pass_early: done=%b busy=%b, want 0 1", done, busy); n_fail++;
    end
    wb(32'h08, 32'd12);
    n_checks++;
    if (pass !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || cpu_resetn !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL pass_verdict: pass=%b done=%b busy=%b rn=%b to=%b, want 1 1 0 0 0",
               pass, done, busy, cpu_resetn, timeout); n_fail++;
    end
    n_checks++;
    if (cycle_cnt !== 3'd3) begin $display("FAIL pass_cycle_cnt: got %0d, want 3", cycle_cnt); n_fail++; end
  endtask

  task automatic test_mismatch();
    int n;
    kick(3);
    n_checks++;
    if (pass !== 1'b0 || done !== 1'b0 || cycle_cnt !== '0 || busy !== 1'b1) begin
      $display("FAIL restart_clear: pass=%b done=%b cnt=%0d busy=%b, want 0 0 0 1",
               pass, done, cycle_cnt, busy); n_fail++;
    end
    wait_run(n);
    wb(32'h00, 32'd5);
    wb(32'h04, 32'd8);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL mismatch_verdict: done=%b pass=%b to=%b, want 1 0 0", done, pass, timeout); n_fail++;
    end
    n_checks++;
    if (fail_idx !== 4'd1 || fail_pc !== 32'h04 || fail_got !== 32'd8) begin
      $display("FAIL mismatch_capture: idx=%0d pc=%0h got=%0d, want 1 4 8", fail_idx, fail_pc, fail_got); n_fail++;
    end
  endtask

  task automatic test_timeout();
    int n;
    kick(1);
    wait_run(n);
    cpu_pc = 32'h40;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== TIMEOUT) begin $display("FAIL timeout_cycles: got %0d, want %0d", n, TIMEOUT); n_fail++; end
    n_checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || fail_idx !== 4'd0 || fail_pc !== 32'h40 || fail_got !== '0) begin
      $display("FAIL timeout_capture: to=%b pass=%b idx=%0d pc=%0h got=%0h, want 1 0 0 40 0",
               timeout, pass, fail_idx, fail_pc, fail_got); n_fail++;
    end
    n_checks++;
    if (cycle_cnt !== 3'd7) begin $display("FAIL cycle_cnt_saturate: got %0d, want 7", cycle_cnt); n_fail++; end
  endtask

  task automatic test_wb_priority();
    int n;
    kick(1);
    wait_run(n);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    wb(32'h00, 32'd5);
    n_checks++;
    if (pass !== 1'b1 || timeout !== 1'b0) begin
      $display("FAIL wb_over_timeout: pass=%b to=%b, want 1 0", pass, timeout); n_fail++;
    end
  endtask

  task automatic test_zero_and_start_in_hold();
    int n;
    kick(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 2;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== HOLD + 1) begin $display("FAIL zero_hold_len: got %0d busy samples+1, want %0d", n, HOLD + 1); n_fail++; end
    n_checks++;
    if (pass !== 1'b1 || done !== 1'b1 || cycle_cnt !== '0 || cpu_resetn !== 1'b0) begin
      $display("FAIL zero_entries: pass=%b done=%b cnt=%0d rn=%b, want 1 1 0 0",
               pass, done, cycle_cnt, cpu_resetn); n_fail++;
    end
  endtask

  task automatic test_clamp_full_depth();
    int n;
    bit early;
    for (int i = 0; i < DEPTH; i++) load(i, DATA_W'(4 * i), DATA_W'(3 * i + 1));
    kick(31);
    wait_run(n);
    early = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (done) early = 1'b1;
      wb(DATA_W'(4 * i), DATA_W'(3 * i + 1));
    end
    n_checks++;
    if (early || pass !== 1'b1) begin
      $display("FAIL clamp_depth: early=%b pass=%b, want 0 1", early, pass); n_fail++;
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    load3();
    kick(3);
    wait_run(n);
    wb(32'h00, 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_resetn !== 1'b0 || cycle_cnt !== '0) begin
      $display("FAIL reset_abort: busy=%b done=%b rn=%b cnt=%0d, want 0 0 0 0",
               busy, done, cpu_resetn, cycle_cnt); n_fail++;
    end
    kick(3);
    wait_run(n);
    wb(32'h00, 32'd5);
    wb(32'h04, 32'd7);
    wb(32'h08, 32'd12);
    n_checks++;
    if (pass !== 1'b1) begin $display("FAIL restart_after_reset: pass=%b, want 1", pass); n_fail++; end
  endtask

  task automatic test_load_in_run();
    int n;
    kick(3);
    wait_run(n);
    load_en = 1'b1; load_idx = 4'd2; load_pc = 32'h08; load_res = 32'd99;
    wb(32'h00, 32'd5);
    load_en = 1'b0;
    wb(32'h04, 32'd7);
    wb(32'h08, 32'd12);
    n_checks++;
    if (pass !== 1'b1) begin $display("FAIL load_ignored_in_run: pass=%b, want 1", pass); n_fail++; end
    load(2, 32'h08, 32'd99);
    kick(3);
    wait_run(n);
    wb(32'h00, 32'd5);
    wb(32'h04, 32'd7);
    wb(32'h08, 32'd99);
    n_checks++;
    if (pass !== 1'b1) begin $display("FAIL load_in_pass: pass=%b, want 1", pass); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_wb_priority();
    test_zero_and_start_in_hold();
    test_clamp_full_depth();
    test_reset_mid_run();
    test_load_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Synthesizable, parametrised run controller and self-checker for the single-cycle CPU core.
- Sequences the core's reset, then watches its debug bus (PC, ALU result, register-write strobe) and compares every register write-back against a loaded expected trace.
- Reports pass/fail, the first mismatching entry, or a timeout.
- Replaces hand-inspected waveform checks, so on-board and simulation runs share one checker.

Parameters:
- DATA_W, 32, width of PC and result buses
- DEPTH, 16, number of expected-trace entries
- IDX_W, 4, index width; must satisfy 2**IDX_W >= DEPTH
- HOLD, 4, cycles the core is held in reset after start (>= 1)
- TIMEOUT, 1024, maximum RUN cycles without a matching write-back
- CNT_W, 16, cycle counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- load_en  in  1  write expected entry at load_idx
- load_idx  in  IDX_W  expected-entry index
- load_pc  in  DATA_W  expected PC of the write-back instruction
- load_res  in  DATA_W  expected eresult value
- n_expected  in  IDX_W+1  number of entries to check (0..DEPTH); sampled on start
- start  in  1  begin a run (one-cycle pulse)
- cpu_resetn  out  1  active-low reset driven to the core
- cpu_pc  in  DATA_W  core PC (address)
- cpu_eresult  in  DATA_W  core ALU result
- cpu_wreg  in  1  core register-write strobe
- busy  out  1  high in HOLD or RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- timeout  out  1  fail caused by TIMEOUT
- fail_idx  out  IDX_W  entry index at failure
- fail_pc  out  DATA_W  cpu_pc captured at failure
- fail_got  out  DATA_W  cpu_eresult captured at failure
- cycle_cnt  out  CNT_W  RUN cycles elapsed; saturates at all-ones

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; cpu_resetn=0.
  - busy, done, pass, timeout = 0.
  - fail_idx, fail_pc, fail_got, cycle_cnt = 0.
  - Trace memory contents are not reset.
- Loading: load_en writes {load_pc, load_res} at load_idx on the clock edge.
  - Accepted in IDLE, PASS and FAIL; ignored in HOLD and RUN.
  - load_idx >= DEPTH is ignored.
- FSM:
  - IDLE: cpu_resetn=0. On start, latch n_expected (values > DEPTH are clamped to DEPTH), clear the hold counter, go to HOLD.
  - HOLD: cpu_resetn=0 for exactly HOLD cycles, then go to RUN with ptr=0, cycle_cnt=0 and the idle counter at 0.
    - If the latched n_expected is 0, go to PASS instead of RUN.
  - RUN: cpu_resetn=1; cycle_cnt increments each cycle. On a cycle with cpu_wreg=1:
    - Compare cpu_pc to exp_pc[ptr] and cpu_eresult to exp_res[ptr].
    - Both equal: ptr++ and the idle counter clears; if ptr was n_expected-1, go to PASS next cycle.
    - Either differs: go to FAIL; capture fail_idx=ptr, fail_pc=cpu_pc, fail_got=cpu_eresult; timeout=0.
  - RUN, cycle with cpu_wreg=0: the idle counter increments.
    - When it reaches TIMEOUT, go to FAIL with timeout=1, fail_idx=ptr, fail_pc=cpu_pc, fail_got=0.
  - PASS / FAIL: cpu_resetn=0 (core halted); done=1. Results hold until start (new run, results cleared on entry to HOLD) or reset.
- Latency: a verdict is visible on outputs one cycle after the deciding write-back edge.
- Comparison is registered-free: the core's outputs are sampled on the same edge the FSM advances.
- start is ignored while busy=1. start in PASS/FAIL restarts using the existing trace contents.
- A write-back arriving in the same cycle the idle counter would hit TIMEOUT takes priority; it is compared, not timed out.
- Reset asserted mid-RUN aborts immediately to IDLE; no verdict is produced.
- cycle_cnt saturates at 2**CNT_W-1 and does not wrap.

Test Plan:
- Load 3 entries {0x00,5}, {0x04,7}, {0x08,12}; start; model core emits matching wreg pulses at RUN cycles 1, 2, 3 -> cpu_resetn low for 4 cycles, then pass=1, done=1 one cycle after the third pulse, cycle_cnt=3.
- Same trace, second write-back reports eresult=8 -> FAIL, pass=0, fail_idx=1, fail_pc=0x04, fail_got=8, timeout=0.
- TIMEOUT=8, one expected entry, core never asserts wreg -> done=1, timeout=1, fail_idx=0 after exactly 8 RUN cycles.
- n_expected=0; start -> PASS immediately after the HOLD cycles with cycle_cnt=0; start pulsed again during HOLD -> no effect.
- Reset driven low at RUN cycle 2 of a 3-entry run -> IDLE next cycle, busy=0, done=0, cpu_resetn=0; a restart with start then passes normally.
- load_en with load_idx=2 during RUN changes nothing (run passes on the old trace); the same write in PASS takes effect on the next run.
